dyn_seg_scan: RTL and testbench

//   Parametrised multiplexed 7-segment scan driver for N hex digits with DP.

---
 rtl/dyn_seg_scan_if.sv | 21 ++
 rtl/dyn_seg_scan.sv | 140 ++++++++++++++
 tb/tb_dyn_seg_scan.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dyn_seg_scan_if.sv
// dyn_seg_scan_if: data/strobe inputs and scan outputs of the 7-segment scan driver.
// The master modport drives the data side, and the slave modport is the scan driver itself.
interface dyn_seg_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] data_i;
    logic [DIGITS-1:0]   dp_i;
    logic [DIGITS-1:0]   blank_i;
    logic                load_i;
    logic [DIGITS-1:0]   dig_o;
    logic [7:0]          seg_o;
    logic                frame_end_o;
    modport master (
        output data_i, dp_i, blank_i, load_i,
        input  dig_o, seg_o, frame_end_o
    );
    modport slave (
        input  data_i, dp_i, blank_i, load_i,
        output dig_o, seg_o, frame_end_o
    );
endinterface

// File: rtl/dyn_seg_scan.sv
// dyn_seg_scan: N-digit multiplexed 7-segment scan driver with tear-free loads, guard time and blank mask.
// Define LZ_BLANK_EN to add leading-zero suppression on the displayed data.
module dyn_seg_scan #(
    parameter int DIGITS      = 4,
    parameter int DIV         = 50000,
    parameter int GUARD       = 500,
    parameter bit DIG_ACT_LOW = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b0
) (
    input logic          clk_i,
    input logic          rst_n_i,
    dyn_seg_scan_if.slave bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_data_q, pend_data_d, shd_data_q, shd_data_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, shd_dp_q, shd_dp_d;
    logic [DIGITS-1:0]   pend_blank_q, pend_blank_d, shd_blank_q, shd_blank_d;
    logic                pend_valid_q, pend_valid_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic [7:0]          seg_q, seg_d;
    logic                slot_end, frame_end, guard;
    logic [DIGITS-1:0]   dark;
    logic [3:0]          nib;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h7E;
            4'h1: hex7 = 7'h30;
            4'h2: hex7 = 7'h6D;
            4'h3: hex7 = 7'h79;
            4'h4: hex7 = 7'h33;
            4'h5: hex7 = 7'h5B;
            4'h6: hex7 = 7'h5F;
            4'h7: hex7 = 7'h70;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h7B;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h1F;
            4'hC: hex7 = 7'h4E;
            4'hD: hex7 = 7'h3D;
            4'hE: hex7 = 7'h4F;
            default: hex7 = 7'h47;
        endcase
    endfunction

    assign slot_end  = pcnt_q == PCNT_MAX;
    assign frame_end = slot_end && idx_q == IDX_MAX;

    always_comb begin
        pcnt_d = slot_end ? '0 : pcnt_q + 1'b1;
        idx_d  = slot_end ? ((idx_q == IDX_MAX) ? '0 : idx_q + 1'b1) : idx_q;
    end

    // A LOAD on the frame boundary bypasses pending and discards any older pending data.
    always_comb begin
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        shd_data_d   = shd_data_q;
        shd_dp_d     = shd_dp_q;
        shd_blank_d  = shd_blank_q;
        if (bus.load_i && frame_end) begin
            shd_data_d   = bus.data_i;
            shd_dp_d     = bus.dp_i;
            shd_blank_d  = bus.blank_i;
            pend_valid_d = 1'b0;
        end else if (bus.load_i) begin
            pend_data_d  = bus.data_i;
            pend_dp_d    = bus.dp_i;
            pend_blank_d = bus.blank_i;
            pend_valid_d = 1'b1;
        end else if (frame_end && pend_valid_q) begin
            shd_data_d   = pend_data_q;
            shd_dp_d     = pend_dp_q;
            shd_blank_d  = pend_blank_q;
            pend_valid_d = 1'b0;
        end
    end

`ifdef LZ_BLANK_EN
    logic run;
    always_comb begin
        dark = shd_blank_q;
        run  = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            if (run && shd_data_q[4*k +: 4] == 4'h0 && !shd_dp_q[k]) dark[k] = 1'b1;
            run = run && (shd_data_q[4*k +: 4] == 4'h0 || shd_blank_q[k]) && !shd_dp_q[k];
        end
    end
`else
    assign dark = shd_blank_q;
`endif

    // Polarity is applied only here so the scan logic stays active-high.
    always_comb begin
        guard = int'(pcnt_q) < GUARD;
        nib   = shd_data_q[{idx_q, 2'b00} +: 4];
        dig_d = (guard ? '0 : DIGITS'(1) << idx_q) ^ {DIGITS{DIG_ACT_LOW}};
        seg_d = ((guard || dark[idx_q]) ? 8'h00 : {hex7(nib), shd_dp_q[idx_q]}) ^ {8{SEG_ACT_LOW}};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pcnt_q       <= '0;
            idx_q        <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            shd_data_q   <= '0;
            shd_dp_q     <= '0;
            shd_blank_q  <= '0;
            dig_q        <= {DIGITS{DIG_ACT_LOW}};
            seg_q        <= {8{SEG_ACT_LOW}};
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            shd_data_q   <= shd_data_d;
            shd_dp_q     <= shd_dp_d;
            shd_blank_q  <= shd_blank_d;
            dig_q        <= dig_d;
            seg_q        <= seg_d;
        end
    end

    assign bus.dig_o       = dig_q;
    assign bus.seg_o       = seg_q;
    assign bus.frame_end_o = frame_end;
endmodule

// File: tb/tb_dyn_seg_scan.sv
// tb_dyn_seg_scan: scoreboard bench; every lit scan sample is checked against per-frame expectations.
// Built with LZ_BLANK_EN, the expected frames include leading-zero suppression.
module tb_dyn_seg_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dyn_seg_scan_if #(.DIGITS(4)) bus ();
    dyn_seg_scan #(
        .DIGITS(4), .DIV(4), .GUARD(1), .DIG_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b0)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus.slave)
    );

    typedef struct {
        int          f;
        int          j;
        logic [15:0] d;
        logic [3:0]  p;
        logic [3:0]  b;
    } load_t;

    logic [6:0]  dec [16];
    load_t       loads [8];
    logic [11:0] sbq [$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp = '0, m_blank = '0;

    task automatic push_frame();
        logic [3:0] blk;
        logic       run;
        logic [3:0] n;
        run = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            n = m_data[4*i +: 4];
            blk[i] = m_blank[i];
`ifdef LZ_BLANK_EN
            if (i > 0 && run && n == 4'h0 && !m_dp[i]) blk[i] = 1'b1;
            run = run && (n == 4'h0 || m_blank[i]) && !m_dp[i];
`endif
        end
        for (int i = 0; i < 4; i++) begin
            n = m_data[4*i +: 4];
            for (int r = 0; r < 3; r++)
                sbq.push_back({~(4'b0001 << i), blk[i] ? 8'h00 : {dec[n], m_dp[i]}});
        end
    endtask

    initial begin
        logic [11:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && bus.dig_o !== 4'hF) begin
                n_tests++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL scan_unexpected got dig=%b seg=%h, required dark", bus.dig_o, bus.seg_o);
                end else begin
                    e = sbq.pop_front();
                    if ({bus.dig_o, bus.seg_o} !== e) begin
                        n_fail++;
                        $display("FAIL scan got dig=%b seg=%h, required dig=%b seg=%h",
                                 bus.dig_o, bus.seg_o, e[11:8], e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        int len;
        dec = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        loads = '{
            '{1, 3,  16'h1234, 4'h0, 4'h0},
            '{3, 4,  16'hAAAA, 4'h0, 4'h0},
            '{3, 9,  16'h5555, 4'h0, 4'h0},
            '{4, 5,  16'hAAAA, 4'h0, 4'h0},
            '{4, 16, 16'h00F0, 4'h0, 4'h0},
            '{6, 8,  16'hE8D0, 4'b0001, 4'b0100},
            '{7, 2,  16'h0030, 4'h0, 4'h0},
            '{8, 6,  16'h0000, 4'h0, 4'h0}
        };
        bus.data_i = '0;
        bus.dp_i = '0;
        bus.blank_i = '0;
        bus.load_i = 1'b0;
        repeat (3) @(negedge clk);
        n_tests += 2;
        if (bus.dig_o !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_dig got %b, required 1111", bus.dig_o);
        end
        if (bus.seg_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_seg got %h, required 00", bus.seg_o);
        end
        push_frame();
        rst_n = 1'b1;
        for (int f = 0; f <= 9; f++) begin
            len = (f == 0) ? 15 : 16;
            for (int j = 1; j <= len; j++) begin
                @(negedge clk);
                bus.load_i = 1'b0;
                foreach (loads[k]) if (loads[k].f == f && loads[k].j == j) begin
                    bus.load_i = 1'b1;
                    bus.data_i = loads[k].d;
                    bus.dp_i = loads[k].p;
                    bus.blank_i = loads[k].b;
                    m_data = loads[k].d;
                    m_dp = loads[k].p;
                    m_blank = loads[k].b;
                end
                n_tests++;
                if (bus.frame_end_o !== (j == len)) begin
                    n_fail++;
                    $display("FAIL frame_end f=%0d j=%0d got %b, required %b", f, j, bus.frame_end_o, j == len);
                end
            end
            push_frame();
        end
        @(negedge clk);
        bus.load_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests += 2;
        if (bus.dig_o !== 4'hF) begin
            n_fail++;
            $display("FAIL midreset_dig got %b, required 1111", bus.dig_o);
        end
        if (bus.seg_o !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_seg got %h, required 00", bus.seg_o);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
